// File: rtl/memgame_pkg.sv
// memgame_pkg: move codes and small helpers shared by the move encoder and the game FSM.
// Rev 1.0
`default_nettype none

package memgame_pkg;

  typedef logic [1:0] move_t;
  typedef logic [2:0] state_t;

  localparam move_t MOVE_NONE = 2'b00;
  localparam move_t MOVE_A    = 2'b01;
  localparam move_t MOVE_B    = 2'b10;
  localparam move_t MOVE_C    = 2'b11;

  // A has priority over B, B over C
  function automatic move_t lowest_move(input state_t mask);
    if (mask[0]) return MOVE_A;
    if (mask[1]) return MOVE_B;
    if (mask[2]) return MOVE_C;
    return MOVE_NONE;
  endfunction

  function automatic state_t move_mask(input move_t m);
    case (m)
      MOVE_A:  return 3'b001;
      MOVE_B:  return 3'b010;
      MOVE_C:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/move_input_encoder_if.sv
// move_input_encoder_if: button/enable inputs and move/status outputs of the move encoder.
// Rev 1.0
`default_nettype none

interface move_input_encoder_if;
  import memgame_pkg::*;

  logic [2:0] btn;
  logic       en;
  move_t      x;
  logic [2:0] btn_level;
  state_t     pending;

  modport master (
    output btn,
    output en,
    input  x,
    input  btn_level,
    input  pending
  );

  modport slave (
    input  btn,
    input  en,
    output x,
    output btn_level,
    output pending
  );

endinterface

`default_nettype wire

// File: rtl/button_debouncer.sv
// button_debouncer: synchroniser + stable-count debouncer with a same-edge rising-accept pulse.
// Rev 1.0
`default_nettype none

module button_debouncer #(
  parameter int N_SYNC          = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic raw,
  output logic      level,
  output logic      rise_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_SYNC-1:0] sync;
  logic [CW-1:0]     cnt;
  logic              s;
  logic              accept;

  assign s = sync[N_SYNC-1];

  // rise_pulse is combinational so the top can queue the press on the accepting edge
  assign accept     = (s != level) && (cnt == CNT_MAX);
  assign rise_pulse = accept && s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[N_SYNC-2:0], raw};
      if (s == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/move_input_encoder.sv
// move_input_encoder: debounces three buttons, queues presses and drains them one move per cycle.
// Rev 1.0
`default_nettype none

module move_input_encoder
  import memgame_pkg::*;
#(
  parameter int N_SYNC          = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  wire logic            clk,
  input  wire logic            rst,
  move_input_encoder_if.slave  bus
);

  logic [2:0] level;
  logic [2:0] rise;
  state_t     pend;
  move_t      x_reg;
  move_t      drain_code;
  state_t     drain_clr;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    button_debouncer #(
      .N_SYNC          (N_SYNC),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk        (clk),
      .rst        (rst),
      .raw        (bus.btn[i]),
      .level      (level[i]),
      .rise_pulse (rise[i])
    );
  end

  assign drain_code = lowest_move(pend);
  assign drain_clr  = move_mask(drain_code);

  // New events are OR-ed in after the clear so a same-cycle set of the drained bit survives
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend  <= '0;
      x_reg <= MOVE_NONE;
    end else if (!bus.en) begin
      pend  <= '0;
      x_reg <= MOVE_NONE;
    end else begin
      pend  <= (pend & ~drain_clr) | rise;
      x_reg <= drain_code;
    end
  end

  assign bus.x         = x_reg;
  assign bus.btn_level = level;
  assign bus.pending   = pend;

endmodule

`default_nettype wire

// File: tb/tb_move_input_encoder.sv
// tb_move_input_encoder: vector table, directed corner sequences and random stimulus vs a model.
// Rev 1.0
`default_nettype none

module tb_move_input_encoder;

  localparam int N_SYNC = 2;
  localparam int DEB    = 16;
  localparam int LAT    = N_SYNC + DEB + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  move_input_encoder_if bus ();

  move_input_encoder #(
    .N_SYNC          (N_SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;
  int edge_cnt = 0;
  int ev_edge[$];
  logic [1:0] ev_code[$];

  // Reference model: a delay line for the synchroniser, a run-length of
  // consecutive disagreeing samples per button, and a pending bitmask.
  logic [2:0] m_hist [N_SYNC];
  int         m_run  [3];
  logic [2:0] m_lvl;
  logic [2:0] m_pend;
  logic [1:0] m_x;

  typedef struct {
    logic [2:0] btn;
    logic       en;
    int         hold;
    int         n_exp;
    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_SYNC; k++) m_hist[k] = 3'b000;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    m_lvl  = 3'b000;
    m_pend = 3'b000;
    m_x    = 2'b00;
  endtask

  task automatic model_step();
    logic [2:0] s;
    logic [2:0] rises;
    logic       done;
    s     = m_hist[N_SYNC-1];
    rises = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (s[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i] = s[i];
          m_run[i] = 0;
          rises[i] = s[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    for (int k = N_SYNC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = bus.btn;
    if (!bus.en) begin
      m_pend = 3'b000;
      m_x    = 2'b00;
    end else begin
      m_x  = 2'b00;
      done = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (m_pend[i] && !done) begin
          m_x       = 2'(i + 1);
          m_pend[i] = 1'b0;
          done      = 1'b1;
        end
      end
      m_pend = m_pend | rises;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    edge_cnt++;
    @(negedge clk);
    chk("model_x", 32'(bus.x), 32'(m_x));
    chk("model_btn_level", 32'(bus.btn_level), 32'(m_lvl));
    chk("model_pending", 32'(bus.pending), 32'(m_pend));
    if (bus.x != 2'b00) begin
      ev_edge.push_back(edge_cnt);
      ev_code.push_back(bus.x);
    end
  endtask

  task automatic clear_events();
    ev_edge.delete();
    ev_code.delete();
    edge_cnt = 0;
  endtask

  // Called at a falling edge; holds reset for three cycles with the given inputs
  task automatic do_reset(input logic [2:0] b, input logic e);
    rst = 1'b0;
    model_reset();
    bus.btn = b;
    bus.en  = e;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("reset_x", 32'(bus.x), 32'h0);
      chk("reset_btn_level", 32'(bus.btn_level), 32'h0);
      chk("reset_pending", 32'(bus.pending), 32'h0);
    end
    rst = 1'b1;
    clear_events();
  endtask

  task automatic async_pulse();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    rst = 1'b1;
  endtask

  task automatic expect_events(input string nm, input int n, input logic [1:0] c0,
                               input logic [1:0] c1, input logic [1:0] c2, input int first);
    logic [1:0] codes[3];
    codes[0] = c0;
    codes[1] = c1;
    codes[2] = c2;
    chk({nm, "_count"}, 32'(ev_code.size()), 32'(n));
    for (int k = 0; k < n && k < ev_code.size() && k < 3; k++) begin
      chk({nm, "_code"}, 32'(ev_code[k]), 32'(codes[k]));
      chk({nm, "_edge"}, 32'(ev_edge[k]), 32'(first + k));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rem[3];

    vecs[0] = '{btn: 3'b111, en: 1'b1, hold: 60, n_exp: 3, c0: 2'b01, c1: 2'b10, c2: 2'b11};
    vecs[1] = '{btn: 3'b001, en: 1'b1, hold: 60, n_exp: 1, c0: 2'b01, c1: 2'b00, c2: 2'b00};
    vecs[2] = '{btn: 3'b010, en: 1'b1, hold: 60, n_exp: 1, c0: 2'b10, c1: 2'b00, c2: 2'b00};
    vecs[3] = '{btn: 3'b100, en: 1'b1, hold: 60, n_exp: 1, c0: 2'b11, c1: 2'b00, c2: 2'b00};
    vecs[4] = '{btn: 3'b101, en: 1'b1, hold: 60, n_exp: 2, c0: 2'b01, c1: 2'b11, c2: 2'b00};
    vecs[5] = '{btn: 3'b110, en: 1'b1, hold: 60, n_exp: 2, c0: 2'b10, c1: 2'b11, c2: 2'b00};
    vecs[6] = '{btn: 3'b001, en: 1'b1, hold: DEB-1, n_exp: 0, c0: 2'b00, c1: 2'b00, c2: 2'b00};
    vecs[7] = '{btn: 3'b001, en: 1'b1, hold: DEB, n_exp: 1, c0: 2'b01, c1: 2'b00, c2: 2'b00};
    vecs[8] = '{btn: 3'b011, en: 1'b0, hold: 60, n_exp: 0, c0: 2'b00, c1: 2'b00, c2: 2'b00};

    bus.btn = 3'b000;
    bus.en  = 1'b1;
    model_reset();
    @(negedge clk);

    // Table: buttons held through reset, counted from the first edge after release
    for (int r = 0; r < 9; r++) begin
      do_reset(vecs[r].btn, vecs[r].en);
      repeat (vecs[r].hold) tick();
      bus.btn = 3'b000;
      repeat (40) tick();
      expect_events($sformatf("vec%0d", r), vecs[r].n_exp, vecs[r].c0, vecs[r].c1,
                    vecs[r].c2, LAT);
    end

    // Bounce on B, then a clean rise
    do_reset(3'b000, 1'b1);
    for (int p = 0; p < 14; p++) begin
      bus.btn[1] = (p % 2 == 0);
      repeat (3) tick();
    end
    chk("bounce_quiet", 32'(ev_code.size()), 32'h0);
    clear_events();
    bus.btn = 3'b010;
    repeat (40) tick();
    expect_events("bounce_final", 1, 2'b10, 2'b00, 2'b00, LAT);

    // Long hold of C, then release timing
    do_reset(3'b000, 1'b1);
    bus.btn = 3'b100;
    repeat (200) tick();
    expect_events("held", 1, 2'b11, 2'b00, 2'b00, LAT);
    clear_events();
    bus.btn = 3'b000;
    repeat (N_SYNC + DEB - 1) tick();
    chk("release_level_before", 32'(bus.btn_level[2]), 32'h1);
    tick();
    chk("release_level_after", 32'(bus.btn_level[2]), 32'h0);
    repeat (20) tick();
    chk("release_no_event", 32'(ev_code.size()), 32'h0);

    // Enable handling
    do_reset(3'b000, 1'b0);
    bus.btn = 3'b001;
    repeat (40) tick();
    chk("en0_no_event", 32'(ev_code.size()), 32'h0);
    bus.en = 1'b1;
    repeat (40) tick();
    chk("en_raise_no_replay", 32'(ev_code.size()), 32'h0);
    bus.btn = 3'b000;
    repeat (30) tick();
    clear_events();
    bus.btn = 3'b101;
    repeat (40) tick();
    expect_events("en_ac", 2, 2'b01, 2'b11, 2'b00, LAT);
    bus.btn = 3'b000;
    repeat (30) tick();
    clear_events();
    bus.btn = 3'b101;
    repeat (LAT) tick();
    bus.en = 1'b0;
    repeat (30) tick();
    expect_events("en_drop", 1, 2'b01, 2'b00, 2'b00, LAT);
    chk("en_drop_pending", 32'(bus.pending), 32'h0);

    // Asynchronous reset in the middle of a drain
    do_reset(3'b000, 1'b1);
    bus.btn = 3'b111;
    repeat (N_SYNC + DEB) tick();
    chk("drain_pending_full", 32'(bus.pending), 32'h7);
    tick();
    chk("drain_first_x", 32'(bus.x), 32'h1);
    chk("drain_pending_left", 32'(bus.pending), 32'h6);
    bus.btn = 3'b000;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_x", 32'(bus.x), 32'h0);
    chk("async_pending", 32'(bus.pending), 32'h0);
    rst = 1'b1;
    clear_events();
    repeat (40) tick();
    chk("async_no_more", 32'(ev_code.size()), 32'h0);

    // Random stimulus, checked every cycle by the model
    do_reset(3'b000, 1'b1);
    for (int i = 0; i < 3; i++) rem[i] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (rem[i] == 0) begin
          bus.btn[i] = 1'($urandom_range(0, 1));
          rem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20))
                                                : int'($urandom_range(10, 60));
        end
        rem[i]--;
      end
      if ($urandom_range(0, 299) == 0) bus.en = ~bus.en;
      if ($urandom_range(0, 999) == 0) async_pulse();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
